mcupdowncounter: RTL and testbench
==================================

# mcupdowncounter

Multi-channel, parametrised up/down counter with a per-channel step size, a runtime choice of saturating or wrapping arithmetic, synchronous load, and terminal-count flags. It replaces ad hoc banks of single up/down counters wherever the core keeps several occupancy or credit counts side by side, for example performance-event accumulators and outstanding-request trackers. All channels share one clock and reset and update independently.

## Interface
Parameters:
- WIDTH, 8, counter width per channel in bits (≥2)
- NCH, 4, number of independent channels (≥1)
- STEPW, 4, width of the per-channel step magnitude (1 ≤ STEPW ≤ WIDTH)

Ports (clock and reset are one clock, synchronous active-high reset):
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; clears all state
- en  in  NCH  per-channel count enable
- down  in  NCH  per-channel direction: 1 = subtract step, 0 = add step
- step  in  NCH*STEPW  per-channel step magnitude; channel i uses bits [i*STEPW +: STEPW]
- sat  in  NCH  per-channel mode: 1 = saturate, 0 = wrap modulo 2^WIDTH
- ld  in  NCH  per-channel synchronous load
- ldval  in  WIDTH  load value, shared by every channel with ld set
- clrflags  in  1  clears all sticky flags
- q  out  NCH*WIDTH  counter values; channel i is [i*WIDTH +: WIDTH]
- zero  out  NCH  q_i == 0
- max  out  NCH  q_i == 2^WIDTH-1
- ovf  out  NCH  sticky overflow flag
- unf  out  NCH  sticky underflow flag

## Operation
- Per-channel priority: reset > ld > en > hold.
- ld_i=1: q_i ← ldval. en_i, down_i and step_i are ignored. No flag event.
- en_i=1, ld_i=0, down_i=0: compute s = {1'b0,q_i} + zero-extended step_i in WIDTH+1 bits.
  - Carry (s[WIDTH]=1) is an overflow event.
  - On overflow, sat_i=1 gives q_i ← all ones; sat_i=0 gives q_i ← s[WIDTH-1:0].
- en_i=1, ld_i=0, down_i=1: compute d = {1'b0,q_i} − step_i in WIDTH+1 bits.
  - Borrow (d[WIDTH]=1) is an underflow event.
  - On underflow, sat_i=1 gives q_i ← 0; sat_i=0 gives q_i ← d[WIDTH-1:0].
- An event occurs in both sat and wrap modes.
- A saturated counter stepped further in the same direction stays at its limit and raises the event again on each such step.
- step_i=0 with en_i=1: q_i unchanged, no event.
- zero and max are decoded combinationally from registered q. They carry no extra state.
- Sticky flags: an event sets the flag for that channel and direction. clrflags=1 clears all flags. If a set and clrflags occur in the same cycle, the set wins (the flag reads 1 afterward).
- Channels never interact. Only ldval and clrflags are shared.

## Timing
- Reset values: q=0 on all channels, ovf=0, unf=0. This gives zero=all ones and max=0 after reset.
- Reset asserted mid-count overrides ld and en on that edge. Counting resumes on the first edge with reset=0.
- Latency: inputs sampled at edge k are visible on q, ovf and unf after edge k. zero and max follow q in the same cycle.
- There is no handshake. en, ld and step are level-qualified for exactly one edge.
- Back-to-back operations are fully pipelined at one update per cycle per channel.

## Configuration
- MCUDC_STICKY_FLAGS_EN defined: ovf and unf registers are implemented as described above.
- MCUDC_STICKY_FLAGS_EN undefined: no flag registers. ovf and unf are tied to 0 and clrflags is ignored. Counting, saturation and wrapping behave identically.

## Structure
- Package mcudc_pkg holds:
  - typedef enum {MCUDC_WRAP=0, MCUDC_SAT=1} for sat encoding
  - localparam function for the all-ones limit
- Sub-module udcchannel holds the single-channel datapath: WIDTH+1-bit add/sub, limit mux, q register (flopenr with enable = en|ld), and optional flag flops.
- The top level uses a generate loop of NCH udcchannel instances plus port slicing.

## Test plan
Unless noted, WIDTH=8, NCH=4, STEPW=4 and the macro is defined.
- Reset: hold en=all ones with step=1, then assert reset for 2 cycles. Expect q=0 on all channels, zero=4'b1111, ovf=unf=0, and q does not change during reset.
- Wrap up: ch0 ld=1 with ldval=254, then en with down=0, step=3, sat=0. Expect q0=1 and ovf[0]=1; other channels unchanged.
- Saturate down: ch2 ld with ldval=3, then down=1, step=5, sat=1 for 3 cycles. Expect q2=0 each cycle, unf[2]=1, zero[2]=1.
- Load priority: ch1 ld=1 and en=1 with step=15 and ldval=0x40. Expect q1=0x40 and no flag change.
- Flag race: clrflags=1 on the same edge as a ch3 overflow. Expect ovf[3]=1 and all other flags cleared. On the next cycle, clrflags alone clears ovf[3].
- Macro off: repeat the wrap-up scenario. Expect q0=1 with ovf and unf held at 0 throughout.

Source files
------------

// File: rtl/mcudc_pkg.sv
// Shared types and helpers for the multi-channel up/down counter.
// Optional feature macro used by this slice: MCUDC_STICKY_FLAGS_EN.
package mcudc_pkg;

    typedef enum logic {
        MCUDC_WRAP = 1'b0,
        MCUDC_SAT  = 1'b1
    } mcudc_mode_e;

    // All-ones value of a w-bit counter, usable in localparam expressions.
    function automatic logic [63:0] mcudc_limit(input int unsigned w);
        if (w >= 64) return '1;
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/mcupdowncounter_udcchannel.sv
// Single-channel up/down counter datapath: add/sub with carry/borrow, limit mux, q register.
// Sticky ovf/unf flops exist only when MCUDC_STICKY_FLAGS_EN is defined.
module udcchannel
    import mcudc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEPW = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             down,
    input  logic [STEPW-1:0] step,
    input  logic             sat,
    input  logic             ld,
    input  logic [WIDTH-1:0] ldval,
    input  logic             clrflags,
    output logic [WIDTH-1:0] q,
    output logic             ovf,
    output logic             unf
);

    localparam logic [WIDTH-1:0] LIMIT = WIDTH'(mcudc_limit(WIDTH));

    mcudc_mode_e    mode;
    logic [WIDTH:0] stepx;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic [WIDTH-1:0] nxt;
    logic           ovfev;
    logic           unfev;
    logic           qen;

    assign mode  = mcudc_mode_e'(sat);
    assign stepx = {{(WIDTH + 1 - STEPW){1'b0}}, step};
    assign sum   = {1'b0, q} + stepx;
    assign diff  = {1'b0, q} - stepx;
    assign qen   = en | ld;

    always_comb begin
        nxt   = q;
        ovfev = 1'b0;
        unfev = 1'b0;
        if (ld) begin
            nxt = ldval;
        end else if (down) begin
            unfev = en & diff[WIDTH];
            nxt   = (diff[WIDTH] && mode == MCUDC_SAT) ? '0 : diff[WIDTH-1:0];
        end else begin
            ovfev = en & sum[WIDTH];
            nxt   = (sum[WIDTH] && mode == MCUDC_SAT) ? LIMIT : sum[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset)    q <= '0;
        else if (qen) q <= nxt;
    end

`ifdef MCUDC_STICKY_FLAGS_EN
    // A new event in the same cycle as clrflags leaves the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (ovfev)         ovf <= 1'b1;
            else if (clrflags) ovf <= 1'b0;
            if (unfev)         unf <= 1'b1;
            else if (clrflags) unf <= 1'b0;
        end
    end
`else
    logic unused_clrflags;
    assign unused_clrflags = clrflags ^ ovfev ^ unfev;
    assign ovf = 1'b0;
    assign unf = 1'b0;
`endif

endmodule

// File: rtl/mcupdowncounter.sv
// Multi-channel up/down counter: NCH independent udcchannel slices sharing ldval/clrflags.
// Sticky overflow/underflow flags are built only with MCUDC_STICKY_FLAGS_EN defined.
module mcupdowncounter
    import mcudc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int STEPW = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH-1:0]       en,
    input  logic [NCH-1:0]       down,
    input  logic [NCH*STEPW-1:0] step,
    input  logic [NCH-1:0]       sat,
    input  logic [NCH-1:0]       ld,
    input  logic [WIDTH-1:0]     ldval,
    input  logic                 clrflags,
    output logic [NCH*WIDTH-1:0] q,
    output logic [NCH-1:0]       zero,
    output logic [NCH-1:0]       max,
    output logic [NCH-1:0]       ovf,
    output logic [NCH-1:0]       unf
);

    localparam logic [WIDTH-1:0] LIMIT = WIDTH'(mcudc_limit(WIDTH));

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        udcchannel #(
            .WIDTH(WIDTH),
            .STEPW(STEPW)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .en       (en[i]),
            .down     (down[i]),
            .step     (step[i*STEPW +: STEPW]),
            .sat      (sat[i]),
            .ld       (ld[i]),
            .ldval    (ldval),
            .clrflags (clrflags),
            .q        (q[i*WIDTH +: WIDTH]),
            .ovf      (ovf[i]),
            .unf      (unf[i])
        );

        assign zero[i] = (q[i*WIDTH +: WIDTH] == '0);
        assign max[i]  = (q[i*WIDTH +: WIDTH] == LIMIT);
    end

endmodule

// File: tb/tb_mcupdowncounter.sv
// Randomized bench for mcupdowncounter against an arithmetic reference model,
// plus directed scenarios with literal expectations.
module tb_mcupdowncounter;

    localparam int WIDTH = 8;
    localparam int NCH   = 4;
    localparam int STEPW = 4;
    localparam int MAXV  = (1 << WIDTH) - 1;
`ifdef MCUDC_STICKY_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NCH-1:0]       en, down, sat, ld;
    logic [NCH*STEPW-1:0] step;
    logic [WIDTH-1:0]     ldval;
    logic                 clrflags;
    logic [NCH*WIDTH-1:0] q;
    logic [NCH-1:0]       zero, max, ovf, unf;

    mcupdowncounter #(.WIDTH(WIDTH), .NCH(NCH), .STEPW(STEPW)) dut (
        .clk(clk), .reset(reset), .en(en), .down(down), .step(step), .sat(sat),
        .ld(ld), .ldval(ldval), .clrflags(clrflags), .q(q), .zero(zero),
        .max(max), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    bit checking   = 1'b0;

    int mq[NCH];
    bit mo[NCH];
    bit mu[NCH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the sampled inputs.
    always @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            int  v;
            bit  eo, eu;
            eo = 1'b0;
            eu = 1'b0;
            if (reset) begin
                mq[c] = 0;
                mo[c] = 1'b0;
                mu[c] = 1'b0;
            end else begin
                v = int'(step[c*STEPW +: STEPW]);
                if (ld[c]) begin
                    mq[c] = int'(ldval);
                end else if (en[c]) begin
                    if (down[c]) begin
                        v = mq[c] - v;
                        if (v < 0) begin
                            eu = 1'b1;
                            v  = sat[c] ? 0 : v + MAXV + 1;
                        end
                    end else begin
                        v = mq[c] + v;
                        if (v > MAXV) begin
                            eo = 1'b1;
                            v  = sat[c] ? MAXV : v - MAXV - 1;
                        end
                    end
                    mq[c] = v;
                end
                if (FL) begin
                    mo[c] = eo | (mo[c] & ~clrflags);
                    mu[c] = eu | (mu[c] & ~clrflags);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            for (int c = 0; c < NCH; c++) begin
                chk($sformatf("q[%0d]", c), 32'(q[c*WIDTH +: WIDTH]), 32'(mq[c]));
                chk($sformatf("zero[%0d]", c), 32'(zero[c]), 32'(mq[c] == 0));
                chk($sformatf("max[%0d]", c), 32'(max[c]), 32'(mq[c] == MAXV));
                chk($sformatf("ovf[%0d]", c), 32'(ovf[c]), 32'(mo[c]));
                chk($sformatf("unf[%0d]", c), 32'(unf[c]), 32'(mu[c]));
            end
        end
    end

    task automatic idle();
        reset = 1'b0; en = '0; down = '0; sat = '0; ld = '0;
        step = '0; ldval = '0; clrflags = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [WIDTH-1:0] qch(input int c);
        return q[c*WIDTH +: WIDTH];
    endfunction

    initial begin
        idle();
        reset = 1'b1;
        @(negedge clk);
        tick();
        checking = 1'b1;

        // Count a few cycles, then reset must hold everything at 0.
        reset = 1'b0; en = '1; step = {NCH{4'd1}};
        tick(); tick(); tick();
        chk("pre-reset q0", 32'(qch(0)), 32'd3);
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("reset q", 32'(q), 32'd0);
            chk("reset zero", 32'(zero), 32'hf);
            chk("reset flags", 32'({ovf, unf}), 32'd0);
        end

        // Wrap up on ch0.
        idle(); ld = 4'b0001; ldval = 8'd254;
        tick();
        idle(); en = 4'b0001; step = 16'h0003;
        tick();
        chk("wrap q0", 32'(qch(0)), 32'd1);
        chk("wrap ovf", 32'(ovf), FL ? 32'h1 : 32'h0);
        chk("wrap others", 32'(q[NCH*WIDTH-1:WIDTH]), 32'd0);

        // Saturating down on ch2.
        idle(); ld = 4'b0100; ldval = 8'd3;
        tick();
        idle(); en = 4'b0100; down = 4'b0100; sat = 4'b0100; step = 16'h0500;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("satdn q2", 32'(qch(2)), 32'd0);
            chk("satdn unf", 32'(unf), FL ? 32'h4 : 32'h0);
            chk("satdn zero2", 32'(zero[2]), 32'd1);
        end

        // Load beats enable on ch1.
        idle(); ld = 4'b0010; en = 4'b0010; step = 16'h00f0; ldval = 8'h40;
        tick();
        chk("ldprio q1", 32'(qch(1)), 32'h40);
        chk("ldprio flags", 32'({ovf, unf}), FL ? 32'h14 : 32'h0);

        // Overflow on ch3 coincident with clrflags: the new event survives.
        idle(); ld = 4'b1000; ldval = 8'd250;
        tick();
        idle(); en = 4'b1000; sat = 4'b1000; step = 16'ha000; clrflags = 1'b1;
        tick();
        chk("race q3", 32'(qch(3)), 32'd255);
        chk("race max3", 32'(max[3]), 32'd1);
        chk("race flags", 32'({ovf, unf}), FL ? 32'h80 : 32'h0);
        idle(); clrflags = 1'b1;
        tick();
        chk("race clear", 32'({ovf, unf}), 32'd0);

        // Randomized traffic, checked every cycle by the model comparison.
        for (int n = 0; n < 3000; n++) begin
            reset    = ($urandom_range(0, 199) == 0);
            en       = NCH'($urandom);
            down     = NCH'($urandom);
            sat      = NCH'($urandom);
            step     = (NCH*STEPW)'($urandom);
            ldval    = WIDTH'($urandom);
            clrflags = ($urandom_range(0, 15) == 0);
            for (int c = 0; c < NCH; c++) ld[c] = ($urandom_range(0, 7) == 0);
            tick();
        end

        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
